// File: rtl/aes_pkg.sv
// ---------------------------------------------------------------------------
// aes_pkg : shared AES-128 constants, state enum and round helper functions
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package aes_pkg;

  localparam int AES_NR    = 10;
  localparam int AES_BLK_W = 128;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ROUND = 2'd1,
    DONE  = 2'd2
  } aes_state_e;

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] acc;
    logic [7:0] x;
    acc = '0;
    x   = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) acc = acc ^ x;
      x = xtime(x);
    end
    return acc;
  endfunction

  // Byte n sits at bits [8n:8n+7]; index 4c+r is row r, column c.
  function automatic logic [0:127] shift_rows(input logic [0:127] s);
    logic [0:127] o;
    o = '0;
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++)
        o[8*(4*c+r) +: 8] = s[8*(4*((c+r)%4)+r) +: 8];
    return o;
  endfunction

  function automatic logic [0:127] inv_shift_rows(input logic [0:127] s);
    logic [0:127] o;
    o = '0;
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++)
        o[8*(4*((c+r)%4)+r) +: 8] = s[8*(4*c+r) +: 8];
    return o;
  endfunction

  function automatic logic [0:127] mix_columns(input logic [0:127] s);
    logic [0:127] o;
    logic [7:0]   a0, a1, a2, a3;
    o = '0;
    for (int c = 0; c < 4; c++) begin
      a0 = s[8*(4*c+0) +: 8];
      a1 = s[8*(4*c+1) +: 8];
      a2 = s[8*(4*c+2) +: 8];
      a3 = s[8*(4*c+3) +: 8];
      o[8*(4*c+0) +: 8] = xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3;
      o[8*(4*c+1) +: 8] = a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3;
      o[8*(4*c+2) +: 8] = a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3;
      o[8*(4*c+3) +: 8] = xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3);
    end
    return o;
  endfunction

  function automatic logic [0:127] inv_mix_columns(input logic [0:127] s);
    logic [0:127] o;
    logic [7:0]   coef [0:3];
    logic [7:0]   acc;
    coef[0] = 8'h0e;
    coef[1] = 8'h0b;
    coef[2] = 8'h0d;
    coef[3] = 8'h09;
    o = '0;
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++) begin
        acc = '0;
        for (int k = 0; k < 4; k++)
          acc = acc ^ gf_mul(coef[(k-r+4)%4], s[8*(4*c+k) +: 8]);
        o[8*(4*c+r) +: 8] = acc;
      end
    return o;
  endfunction

endpackage

`default_nettype wire

// File: rtl/aes_sbox.sv
// ---------------------------------------------------------------------------
// aes_sbox : combinational forward AES S-box (GF(2^8) inverse + affine map)
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module aes_sbox
  import aes_pkg::*;
(
  input  logic [7:0] byte_i,
  output logic [7:0] byte_o
);

  logic [7:0] pow_w;
  logic [7:0] inv_w;

  // a^254 = product of a^(2^i), i = 1..7; maps 0 to 0 as AES requires.
  always_comb begin
    pow_w = byte_i;
    inv_w = 8'h01;
    for (int i = 1; i < 8; i++) begin
      pow_w = gf_mul(pow_w, pow_w);
      inv_w = gf_mul(inv_w, pow_w);
    end
    byte_o = inv_w
           ^ {inv_w[6:0], inv_w[7]}
           ^ {inv_w[5:0], inv_w[7:6]}
           ^ {inv_w[4:0], inv_w[7:5]}
           ^ {inv_w[3:0], inv_w[7:4]}
           ^ 8'h63;
  end

endmodule

`default_nettype wire

// File: rtl/aes_encrypt_iter.sv
// ---------------------------------------------------------------------------
// aes_encrypt_iter : iterative AES-128 encryptor, one round per clock
// Optional block counter output blk_cnt when AES_ENC_CNT_EN is defined. Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module aes_encrypt_iter
  import aes_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [0:AES_BLK_W-1] data_in,
  output logic [3:0]           key_idx,
  input  logic [0:AES_BLK_W-1] key_in,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [0:AES_BLK_W-1] data_out
`ifdef AES_ENC_CNT_EN
  ,
  output logic [15:0]          blk_cnt
`endif
);

  aes_state_e           state_q;
  logic [3:0]           rnd_q;
  logic [0:AES_BLK_W-1] blk_q;

  logic [0:AES_BLK_W-1] sub_w;
  logic [0:AES_BLK_W-1] shr_w;
  logic [0:AES_BLK_W-1] mix_w;
  logic [0:AES_BLK_W-1] round_d;

  for (genvar i = 0; i < 16; i++) begin : g_sbox
    aes_sbox u_sbox (
      .byte_i (blk_q[8*i +: 8]),
      .byte_o (sub_w[8*i +: 8])
    );
  end

  // The last round skips MixColumns.
  always_comb begin
    shr_w   = shift_rows(sub_w);
    mix_w   = mix_columns(shr_w);
    round_d = ((rnd_q == 4'(AES_NR)) ? shr_w : mix_w) ^ key_in;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      rnd_q   <= 4'd0;
      blk_q   <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (in_valid) begin
            blk_q   <= data_in ^ key_in;
            rnd_q   <= 4'd1;
            state_q <= ROUND;
          end
        end
        ROUND: begin
          blk_q <= round_d;
          if (rnd_q == 4'(AES_NR)) begin
            rnd_q   <= 4'd0;
            state_q <= DONE;
          end else begin
            rnd_q <= rnd_q + 4'd1;
          end
        end
        DONE: begin
          if (out_ready) state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign key_idx   = (state_q == ROUND) ? rnd_q : 4'd0;
  assign data_out  = blk_q;

`ifdef AES_ENC_CNT_EN
  logic [15:0] blk_cnt_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)                        blk_cnt_q <= 16'd0;
    else if (out_valid && out_ready) blk_cnt_q <= blk_cnt_q + 16'd1;
  end

  assign blk_cnt = blk_cnt_q;
`endif

endmodule

`default_nettype wire
